// File: rtl/debug_ocimem_ctrl.sv
// Nios II OCI debug memory-access engine: single-word Avalon-MM reads/writes driven by JTAG debug strobes.
// Optional wait-request abort enabled by defining DEBUG_OCIMEM_TIMEOUT_EN.
module debug_ocimem_ctrl #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] mon_a_reg, mon_a_nxt;
    logic [31:0]       mon_d_nxt;
    logic              err_nxt;
    logic              any_strobe;
    logic              timeout_hit;

    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

`ifdef DEBUG_OCIMEM_TIMEOUT_EN
    logic [15:0] wait_cnt;

    // Counter is held at zero while idle, so it restarts on every entry to RD/WR.
    always_ff @(posedge clk) begin
        if (!reset_n || state == IDLE) begin
            wait_cnt <= '0;
        end else if (avm_waitrequest) begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end

    assign timeout_hit = avm_waitrequest && (wait_cnt == 16'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        mon_a_nxt = mon_a_reg;
        mon_d_nxt = MonDReg;
        err_nxt   = monitor_error;
        case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    mon_a_nxt = jdo[16+ADDR_W:17];
                    err_nxt   = 1'b0;
                    if (jdo[34]) begin
                        state_nxt = RD;
                    end
                end else if (take_action_ocimem_b) begin
                    mon_d_nxt = jdo[34:3];
                    state_nxt = WR;
                end else if (take_no_action_ocimem_a) begin
                    state_nxt = RD;
                end
            end
            RD, WR: begin
                // Any strobe while busy is dropped and flagged, including an address load.
                if (any_strobe) begin
                    err_nxt = 1'b1;
                end
                if (!avm_waitrequest) begin
                    if (state == RD) begin
                        mon_d_nxt = avm_readdata;
                    end
                    mon_a_nxt = mon_a_reg + ADDR_W'(1);
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    mon_d_nxt = 32'hDEADBEEF;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_a_reg     <= '0;
            MonDReg       <= '0;
            monitor_error <= 1'b0;
        end else begin
            state         <= state_nxt;
            mon_a_reg     <= mon_a_nxt;
            MonDReg       <= mon_d_nxt;
            monitor_error <= err_nxt;
        end
    end

    assign avm_read      = (state == RD);
    assign avm_write     = (state == WR);
    assign avm_address   = mon_a_reg;
    assign avm_writedata = MonDReg;
    assign monitor_ready = (state == IDLE);

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// Directed self-checking bench for debug_ocimem_ctrl (ADDR_W=9, TIMEOUT=8).
module tb_debug_ocimem_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [8:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    debug_ocimem_ctrl #(
        .ADDR_W (9),
        .TIMEOUT(8)
    ) dut (
        .clk                    (clk),
        .reset_n                (reset_n),
        .jdo                    (jdo),
        .take_action_ocimem_a   (take_action_ocimem_a),
        .take_action_ocimem_b   (take_action_ocimem_b),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .avm_address            (avm_address),
        .avm_read               (avm_read),
        .avm_write              (avm_write),
        .avm_writedata          (avm_writedata),
        .avm_readdata           (avm_readdata),
        .avm_waitrequest        (avm_waitrequest),
        .MonDReg                (MonDReg),
        .monitor_ready          (monitor_ready),
        .monitor_error          (monitor_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk_a(input logic [8:0] addr, input logic rd);
        logic [37:0] v;
        v        = '0;
        v[25:17] = addr;
        v[34]    = rd;
        return v;
    endfunction

    function automatic logic [37:0] mk_b(input logic [31:0] data);
        logic [37:0] v;
        v       = '0;
        v[34:3] = data;
        return v;
    endfunction

    initial begin
        reset_n                 = 1'b0;
        jdo                     = '0;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        avm_readdata            = '0;
        avm_waitrequest         = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(monitor_ready), 32'd1);
        chk("rst_error", 32'(monitor_error), 32'd0);
        chk("rst_mondreg", MonDReg, 32'h0);
        chk("rst_read", 32'(avm_read), 32'd0);
        chk("rst_write", 32'(avm_write), 32'd0);
        chk("rst_addr", 32'(avm_address), 32'h0);
        chk("rst_wdata", avm_writedata, 32'h0);
        reset_n = 1'b1;
        tick();

        // Address load with read, zero waits
        jdo                  = mk_a(9'h010, 1'b1);
        take_action_ocimem_a = 1'b1;
        avm_readdata         = 32'hCAFE0001;
        tick();
        take_action_ocimem_a = 1'b0;
        chk("ld_rd_read", 32'(avm_read), 32'd1);
        chk("ld_rd_addr", 32'(avm_address), 32'h010);
        chk("ld_rd_busy", 32'(monitor_ready), 32'd0);
        tick();
        chk("ld_rd_done", 32'(avm_read), 32'd0);
        chk("ld_rd_data", MonDReg, 32'hCAFE0001);
        chk("ld_rd_inc", 32'(avm_address), 32'h011);
        chk("ld_rd_ready", 32'(monitor_ready), 32'd1);

        // Write with three wait cycles
        jdo                  = mk_b(32'h12345678);
        take_action_ocimem_b = 1'b1;
        avm_waitrequest      = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("wr_write", 32'(avm_write), 32'd1);
            chk("wr_wdata", avm_writedata, 32'h12345678);
            chk("wr_addr", 32'(avm_address), 32'h011);
            if (i < 3) tick();
        end
        avm_waitrequest = 1'b0;
        tick();
        chk("wr_done", 32'(avm_write), 32'd0);
        chk("wr_inc", 32'(avm_address), 32'h012);
        chk("wr_ready", 32'(monitor_ready), 32'd1);

        // Wrap: load 1FF without read, then two next-word reads
        jdo                  = mk_a(9'h1FF, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        chk("wrap_load_addr", 32'(avm_address), 32'h1FF);
        chk("wrap_load_idle", 32'(monitor_ready), 32'd1);
        take_no_action_ocimem_a = 1'b1;
        avm_readdata            = 32'h00001111;
        tick();
        take_no_action_ocimem_a = 1'b0;
        chk("wrap_rd1_read", 32'(avm_read), 32'd1);
        chk("wrap_rd1_addr", 32'(avm_address), 32'h1FF);
        tick();
        chk("wrap_rd1_data", MonDReg, 32'h00001111);
        chk("wrap_rd1_inc", 32'(avm_address), 32'h000);
        take_no_action_ocimem_a = 1'b1;
        avm_readdata            = 32'h22222222;
        tick();
        take_no_action_ocimem_a = 1'b0;
        chk("wrap_rd2_addr", 32'(avm_address), 32'h000);
        chk("wrap_rd2_read", 32'(avm_read), 32'd1);
        tick();
        chk("wrap_rd2_data", MonDReg, 32'h22222222);
        chk("wrap_rd2_inc", 32'(avm_address), 32'h001);

        // Strobes while busy are dropped and flag an error
        take_no_action_ocimem_a = 1'b1;
        avm_waitrequest         = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        chk("busy_read", 32'(avm_read), 32'd1);
        chk("busy_err0", 32'(monitor_error), 32'd0);
        jdo                  = mk_b(32'hAAAA5555);
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_b = 1'b0;
        chk("busy_b_err", 32'(monitor_error), 32'd1);
        chk("busy_b_nowr", 32'(avm_write), 32'd0);
        chk("busy_b_read", 32'(avm_read), 32'd1);
        jdo                  = mk_a(9'h0C3, 1'b1);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        chk("busy_a_err", 32'(monitor_error), 32'd1);
        chk("busy_a_addr", 32'(avm_address), 32'h001);
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h33333333;
        tick();
        chk("busy_done_ready", 32'(monitor_ready), 32'd1);
        chk("busy_done_data", MonDReg, 32'h33333333);
        chk("busy_done_err", 32'(monitor_error), 32'd1);
        chk("busy_done_addr", 32'(avm_address), 32'h002);
        jdo                  = mk_a(9'h055, 1'b0);
        take_action_ocimem_a = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        chk("clr_err", 32'(monitor_error), 32'd0);
        chk("clr_addr", 32'(avm_address), 32'h055);

        // Simultaneous a+b: only the address load takes effect
        jdo                  = mk_a(9'h0AA, 1'b0);
        take_action_ocimem_a = 1'b1;
        take_action_ocimem_b = 1'b1;
        tick();
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        chk("prio_ready", 32'(monitor_ready), 32'd1);
        chk("prio_nowr", 32'(avm_write), 32'd0);
        chk("prio_addr", 32'(avm_address), 32'h0AA);
        chk("prio_data", MonDReg, 32'h33333333);
        chk("prio_err", 32'(monitor_error), 32'd0);

`ifdef DEBUG_OCIMEM_TIMEOUT_EN
        // Wait-request held high: abort after TIMEOUT cycles
        take_no_action_ocimem_a = 1'b1;
        avm_waitrequest         = 1'b1;
        tick();
        take_no_action_ocimem_a = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("to_still_read", 32'(avm_read), 32'd1);
        tick();
        chk("to_read_drop", 32'(avm_read), 32'd0);
        chk("to_ready", 32'(monitor_ready), 32'd1);
        chk("to_err", 32'(monitor_error), 32'd1);
        chk("to_data", MonDReg, 32'hDEADBEEF);
        chk("to_addr", 32'(avm_address), 32'h0AA);
        avm_waitrequest = 1'b0;
`endif

        // Reset during a read: request dropped, no completion
        take_no_action_ocimem_a = 1'b1;
        avm_waitrequest         = 1'b1;
        avm_readdata            = 32'h77777777;
        tick();
        take_no_action_ocimem_a = 1'b0;
        chk("mrst_read", 32'(avm_read), 32'd1);
        reset_n         = 1'b0;
        avm_waitrequest = 1'b0;
        tick();
        chk("mrst_read_drop", 32'(avm_read), 32'd0);
        chk("mrst_write", 32'(avm_write), 32'd0);
        chk("mrst_ready", 32'(monitor_ready), 32'd1);
        chk("mrst_err", 32'(monitor_error), 32'd0);
        chk("mrst_data", MonDReg, 32'h0);
        chk("mrst_addr", 32'(avm_address), 32'h0);
        chk("mrst_wdata", avm_writedata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/debug_ocimem_ctrl.md
# debug_ocimem_ctrl

Debug memory-access engine for the Nios II on-chip debug path. Consumes the `jdo` payload and the `take_action_ocimem_*` strobes produced by the debug-slave system-clock stage. Executes single-word reads and writes on an Avalon-MM master port. Returns `MonDReg`, `monitor_ready` and `monitor_error` to the debug-slave TCK stage for JTAG capture.

## Interface

Parameters:
- `ADDR_W`, 9 — word-address width; range 1..17.
- `TIMEOUT`, 255 — maximum wait-request cycles before abort; range 1..65535.

Ports:
- `clk` input 1 — system clock. This is the only clock.
- `reset_n` input 1 — reset. Synchronous and active-low.
- `jdo` input 38 — debug command payload from the sysclk stage.
- `take_action_ocimem_a` input 1 — single-cycle strobe: load address, optional read.
- `take_action_ocimem_b` input 1 — single-cycle strobe: write data.
- `take_no_action_ocimem_a` input 1 — single-cycle strobe: read next word.
- `avm_address` output ADDR_W — word address.
- `avm_read` output 1 — read request.
- `avm_write` output 1 — write request.
- `avm_writedata` output 32 — write data.
- `avm_readdata` input 32 — read data; valid when `avm_read` is high and `avm_waitrequest` is low.
- `avm_waitrequest` input 1 — slave stall.
- `MonDReg` output 32 — monitor data register.
- `monitor_ready` output 1 — high when idle.
- `monitor_error` output 1 — sticky error flag.

## Operation

Registers:
- `MonAReg` holds the ADDR_W-bit address.
- `MonDReg` holds 32-bit data.
- The FSM has states IDLE, RD, WR.

Commands, accepted only in IDLE:
- **`take_action_ocimem_a`:** `MonAReg <= jdo[16+ADDR_W:17]`. Clears `monitor_error`. If `jdo[34]`=1, go to RD at the new address. Otherwise stay in IDLE.
- **`take_action_ocimem_b`:** `MonDReg <= jdo[34:3]`, then go to WR at `MonAReg`.
- **`take_no_action_ocimem_a`:** go to RD at `MonAReg`.

Simultaneous strobes:
- Priority is a > b > no_action_a. Lower-priority strobes in the same cycle are discarded without error.

Strobe arriving in RD or WR:
- The command is dropped and `monitor_error` is set to 1.
- Exception: `take_action_ocimem_a` is still dropped, but it does not clear the error.

RD state:
- `avm_read`=1 and `avm_address`=`MonAReg`.
- On the first cycle with `avm_waitrequest`=0: `MonDReg <= avm_readdata`, `MonAReg <= MonAReg+1`, return to IDLE.

WR state:
- `avm_write`=1 and `avm_writedata`=`MonDReg`.
- On the first cycle with `avm_waitrequest`=0: `MonAReg <= MonAReg+1`, return to IDLE.

Arithmetic:
- The `MonAReg` increment is modulo 2^ADDR_W, so all-ones wraps to 0.
- An address load via `take_action_ocimem_a` with `jdo[34]`=1 does not pre-increment. The post-increment happens only on transfer completion.

Outputs and reset:
- `monitor_ready` = 1 exactly when the state is IDLE.
- Reset values: state IDLE, `monitor_ready`=1, `monitor_error`=0, `MonDReg`=0, `MonAReg`=0, `avm_read`=0, `avm_write`=0, `avm_address`=0, `avm_writedata`=0.
- Reset asserted mid-transfer drops the request in the same edge, with no completion and no `MonDReg` update.

## Timing

- A strobe at edge N puts `avm_read`/`avm_write` high from cycle N+1. `monitor_ready` falls at N+1.
- With zero wait states, completion is at edge N+2. `MonDReg` is valid and `monitor_ready`=1 from N+2 onward.
- Each wait-request cycle adds one cycle of latency.
- Requests are registered outputs. `avm_address`, `avm_writedata` and `avm_read`/`avm_write` stay stable while `avm_waitrequest`=1.
- A new strobe may be accepted in the same cycle that `monitor_ready` returns high.

## Configuration

Macro `DEBUG_OCIMEM_TIMEOUT_EN`.

Defined:
- A 16-bit counter runs in RD/WR and resets on entry.
- If `avm_waitrequest` stays high for TIMEOUT consecutive cycles, the request is deasserted and the FSM returns to IDLE.
- On abort: `monitor_error`=1, `MonDReg`=32'hDEADBEEF, and `MonAReg` is unchanged.

Undefined:
- The counter is absent and the FSM waits indefinitely.
- `monitor_error` is set only by dropped commands.

## Test plan

- **Address load and read:** `take_action_ocimem_a` with `jdo[25:17]`=9'h010 and `jdo[34]`=1; slave returns 32'hCAFE0001 with 0 waits. Expect `avm_read` at address 0x010 for one cycle, `MonDReg`=32'hCAFE0001, `MonAReg`=0x011, and `monitor_ready` high at N+2.
- **Write with waits:** `take_action_ocimem_b` with `jdo[34:3]`=32'h12345678; `avm_waitrequest` high for 3 cycles. Expect `avm_write` high for 4 cycles with stable data/address, then `MonAReg` incremented.
- **Wrap and burst:** `MonAReg`=9'h1FF, then `take_no_action_ocimem_a` twice. Expect reads at 0x1FF then 0x000.
- **Busy drop and priority:** strobe during RD. Expect the command ignored and `monitor_error`=1; the next `take_action_ocimem_a` clears it. Simultaneous a+b strobes: expect only the address load.
- **Timeout (macro defined):** `avm_waitrequest` held high with TIMEOUT=8. Expect abort after 8 cycles, `MonDReg`=32'hDEADBEEF, `monitor_error`=1, `monitor_ready`=1.
- **Reset mid-read:** `reset_n`=0 during RD. Expect all outputs at reset values on the next edge.
